// File: rtl/block_serial_subtractor_pkg.sv
// block_serial_subtractor_pkg: shared chunk width, FSM encoding and counter sizing
package block_serial_subtractor_pkg;
  localparam int CHUNK = 4;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;
  function automatic int cnt_w(input int n);
    return ($clog2(n / CHUNK) < 1) ? 1 : $clog2(n / CHUNK);
  endfunction
endpackage

// File: rtl/block_serial_subtractor_sub4.sv
// sub4_borrow: combinational 4-bit ripple-borrow cell computing x - y - bi as x + ~y + ~bi
module sub4_borrow
  import block_serial_subtractor_pkg::*;
(
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             bi,
  output logic [CHUNK-1:0] d,
  output logic             bo,
  output logic             b_msb_in
);
  logic [CHUNK:0] c;
  always_comb begin
    c = '0;
    d = '0;
    c[0] = ~bi;
    for (int i = 0; i < CHUNK; i++) begin
      d[i]   = x[i] ^ ~y[i] ^ c[i];
      c[i+1] = (x[i] & ~y[i]) | (c[i] & (x[i] ^ ~y[i]));
    end
  end
  assign bo       = ~c[CHUNK];
  assign b_msb_in = ~c[CHUNK-1];
endmodule

// File: rtl/block_serial_subtractor.sv
// block_serial_subtractor: N-bit a - b - bin, one 4-bit chunk per clock, LSB chunk first
module block_serial_subtractor
  import block_serial_subtractor_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         overflow
);
  localparam int W = cnt_w(N);
  localparam logic [W-1:0] LAST = W'(N / CHUNK - 1);
  state_t state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [N-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic brw_q, brw_d, bout_q, bout_d, ovf_q, ovf_d;
  logic [CHUNK-1:0] d;
  logic bo, b_msb_in;
  sub4_borrow u_cell (
    .x        (a_q[CHUNK-1:0]),
    .y        (b_q[CHUNK-1:0]),
    .bi       (brw_q),
    .d        (d),
    .bo       (bo),
    .b_msb_in (b_msb_in)
  );
  // operands shift right each RUN cycle so the cell always sees chunk 0 of the regs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = RUN;
        a_d     = a;
        b_d     = b;
        brw_d   = bin;
        cnt_d   = '0;
        diff_d  = '0;
      end
      RUN: begin
        a_d    = a_q >> CHUNK;
        b_d    = b_q >> CHUNK;
        brw_d  = bo;
        diff_d = diff_q | (N'(d) << (cnt_q * CHUNK));
        cnt_d  = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          bout_d  = bo;
          ovf_d   = b_msb_in ^ bo;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_block_serial_subtractor.sv
// tb_block_serial_subtractor: directed vectors with hand-computed results for the serial subtractor
module tb_block_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, bin = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic in_ready, out_valid, bout, overflow;
  logic [31:0] diff;
  int checks = 0;
  int errs = 0;
  always #5 clk = ~clk;
  block_serial_subtractor #(.N(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .overflow  (overflow)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic op(input string tag, input logic [31:0] xa, input logic [31:0] xb, input logic xbin,
                    input logic [31:0] ed, input logic eb, input logic eo, input int hold);
    int n;
    @(negedge clk);
    a = xa; b = xb; bin = xbin; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = ~xa; b = ~xb; bin = ~xbin;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd8);
    chk({tag, "_diff"}, 64'(diff), 64'(ed));
    chk({tag, "_bout"}, 64'(bout), 64'(eb));
    chk({tag, "_ovf"}, 64'(overflow), 64'(eo));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      a = 32'h0000_0001; b = 32'h0000_0002; in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
      chk({tag, "_hold_vld"}, 64'(out_valid), 64'd1);
      chk({tag, "_hold_diff"}, 64'({diff, bout, overflow}), 64'({ed, eb, eo}));
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_rdy_after"}, 64'(in_ready), 64'd1);
    chk({tag, "_vld_after"}, 64'(out_valid), 64'd0);
  endtask
  initial begin
    #12;
    chk("rst_diff", 64'(diff), 64'd0);
    chk("rst_flags", 64'({bout, overflow, out_valid, in_ready}), 64'b0001);
    @(negedge clk);
    rst_n = 1'b1;
    op("basic", 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 0);
    op("bin", 32'h0000_0010, 32'h0000_000F, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 0);
    op("ripple", 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
    op("ovf_neg", 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 0);
    op("ovf_pos", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 0);
    op("mixed", 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 32'hEDCB_A986, 1'b0, 1'b0, 0);
    op("bkpr", 32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 1'b0, 5);
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'h0000_0001; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_diff", 64'(diff), 64'd0);
    chk("midrst_vld", 64'(out_valid), 64'd0);
    chk("midrst_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    op("post_rst", 32'h1234_5678, 32'h0234_5678, 1'b0, 32'h1000_0000, 1'b0, 1'b0, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/block_serial_subtractor.md
Name: block_serial_subtractor

Overview:
- Multi-cycle two's-complement subtractor: computes diff = a - b - bin over N bits.
- Processes one 4-bit chunk per clock, LSB chunk first, and carries the borrow between chunks in a register.
- Serves as the area-lean subtract path next to the parallel adders.
- Valid/ready handshake on both the operand and result sides.

Parameters:
- N, 32, operand width; must be a multiple of 4 and >= 8 (other values unsupported).
- CHUNK, 4, bits per cycle; fixed, taken from the shared package.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operands a/b/bin are valid.
- in_ready  out  1  block can accept operands.
- a  in  N  minuend, unsigned or two's-complement.
- b  in  N  subtrahend.
- bin  in  1  borrow in.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer takes the result.
- diff  out  N  a - b - bin, modulo 2^N.
- bout  out  1  unsigned borrow out; 1 iff a < b + bin.
- overflow  out  1  signed overflow; borrow into bit N-1 XOR borrow out of bit N-1.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, count=0, borrow reg=0, operand regs=0.
  - diff=0, bout=0, overflow=0, out_valid=0, in_ready=1 (in_ready is driven from state).
- Reset mid-operation abandons the operation; no partial result is ever presented.
- FSM states IDLE, RUN, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
- IDLE:
  - On in_valid & in_ready at an edge: latch a, b; borrow reg <= bin; count <= 0; diff <= 0; go to RUN.
  - Otherwise stay in IDLE.
- RUN, each edge:
  - Chunk k = count: d_k = a[4k+3:4k] - b[4k+3:4k] - borrow, done as a 4-bit ripple of a + ~b + ~borrow.
  - Chunk borrow_out = NOT carry_out.
  - diff[4k+3:4k] <= d_k; borrow reg <= chunk borrow_out; count <= count+1.
  - When count==N/4-1:
    - bout <= chunk borrow_out.
    - overflow <= borrow into the MSB cell XOR borrow out of the MSB cell of that chunk.
    - Go to DONE.
- DONE:
  - diff, bout and overflow are held stable while out_ready=0.
  - On out_ready=1 at an edge go to IDLE. A new operation cannot be accepted in the same edge.
- Latency: out_valid rises exactly N/4 edges after the accepting edge (8 for N=32).
- Minimum issue interval is N/4+2 cycles.
- in_valid while not in IDLE is ignored. Operands are sampled only at the accepting edge; later changes to a/b/bin have no effect.
- out_ready while not in DONE is ignored.
- diff bits of chunks not yet processed read 0 during RUN; they are not observable because out_valid=0.
- The count register is max(1, $clog2(N/4)) bits and never wraps past N/4-1.

Decomposition:
- Shared package:
  - CHUNK=4.
  - FSM state typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 returns to IDLE).
  - Helper function for the counter width.
- Sub-module sub4_borrow: combinational 4-bit ripple-borrow cell.
  - Inputs x[3:0], y[3:0], bi.
  - Outputs d[3:0], bo, b_msb_in (borrow into bit 3), for the overflow calculation.
  - Instantiated once and reused every cycle on the selected chunk.

Test Plan (N=32):
- Basic and borrow-in:
  - a=0x00000005, b=0x00000003, bin=0 -> diff=0x00000002, bout=0, overflow=0; out_valid exactly 8 edges after accept.
  - Then a=0x00000010, b=0x0000000F, bin=1 -> diff=0x00000000, bout=0, overflow=0.
- Borrow ripple: a=0x00000000, b=0x00000001, bin=0 -> diff=0xFFFFFFFF, bout=1, overflow=0; the borrow crosses all 8 chunks.
- Signed overflow:
  - a=0x80000000, b=0x00000001 -> diff=0x7FFFFFFF, bout=0, overflow=1.
  - a=0x7FFFFFFF, b=0xFFFFFFFF -> diff=0x80000000, bout=1, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, pulsing in_valid with new operands -> diff/bout/overflow stable, in_ready=0, new operands ignored; out_ready=1 -> IDLE next edge, in_ready=1.
- Reset mid-RUN: assert rst_n=0 asynchronously after chunk 3 -> immediately diff=0, out_valid=0, in_ready=1. After release, a=0x12345678, b=0x02345678 -> diff=0x10000000, bout=0.
- Operand stability: change a/b after the accepting edge -> result reflects the latched values only.
